ahb_apb_arbiter: RTL and testbench

AHB_APB_ARBITER -- requirements
Module: ahb_apb_arbiter

---
 rtl/ahb_apb_arbiter_if.sv | 40 ++++
 rtl/ahb_apb_arbiter.sv | 120 ++++++++++++
 tb/tb_ahb_apb_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_arbiter_if.sv
// Bundles the two AHB masters and the muxed APB-bridge side of the arbiter.
// The arbiter uses modport slave; the traffic source uses modport master.
interface ahb_apb_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              REQ0;
  logic              REQ1;
  logic [1:0]        HTRANS0;
  logic [1:0]        HTRANS1;
  logic [ADDR_W-1:0] HADDR0;
  logic [ADDR_W-1:0] HADDR1;
  logic              HWRITE0;
  logic              HWRITE1;
  logic [DATA_W-1:0] HWDATA0;
  logic [DATA_W-1:0] HWDATA1;
  logic              HREADY_IN;

  logic              GNT0;
  logic              GNT1;
  logic              HSELAPB;
  logic [1:0]        HTRANS;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HMASTER;
  logic              HDVALID;

  modport slave (
    input  REQ0, REQ1, HTRANS0, HTRANS1, HADDR0, HADDR1,
           HWRITE0, HWRITE1, HWDATA0, HWDATA1, HREADY_IN,
    output GNT0, GNT1, HSELAPB, HTRANS, HADDR, HWRITE, HWDATA, HMASTER, HDVALID
  );

  modport master (
    output REQ0, REQ1, HTRANS0, HTRANS1, HADDR0, HADDR1,
           HWRITE0, HWRITE1, HWDATA0, HWDATA1, HREADY_IN,
    input  GNT0, GNT1, HSELAPB, HTRANS, HADDR, HWRITE, HWDATA, HMASTER, HDVALID
  );
endinterface

// File: rtl/ahb_apb_arbiter.sv
// Two-master AHB arbiter in front of an APB bridge: round-robin by default,
// fixed priority (master 0 wins) when ARB_FIXED_PRIO_EN is defined.
module ahb_apb_arbiter (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_apb_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_dmst_p1;
  logic       r_vld_p1;

  logic       w_owned;
  logic       w_own_idx;
  logic       w_own_req;
  logic [1:0] w_own_trans;
  logic       w_rearb;
  logic       w_pick_vld;
  logic       w_pick_idx;
  logic [1:0] w_nxt_state;

  // Unencoded state 2'b11 is treated as unowned so it recovers at the next ready edge.
  assign w_owned     = (r_state == S_OWN0) || (r_state == S_OWN1);
  assign w_own_idx   = (r_state == S_OWN1);
  assign w_own_req   = w_own_idx ? bus.REQ1 : bus.REQ0;
  assign w_own_trans = w_own_idx ? bus.HTRANS1 : bus.HTRANS0;

  // BUSY (01) keeps ownership; only IDLE (00) or a dropped request releases the bus.
  assign w_rearb = bus.HREADY_IN && (!w_owned || !w_own_req || (w_own_trans == 2'b00));

  assign w_pick_vld = bus.REQ0 | bus.REQ1;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick_idx = ~bus.REQ0;
`else
  logic r_last_served;

  assign w_pick_idx = (bus.REQ0 && bus.REQ1) ? ~r_last_served : ~bus.REQ0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_last_served <= 1'b1;
    end else if (w_rearb && w_pick_vld) begin
      r_last_served <= w_pick_idx;
    end
  end
`endif

  always_comb begin
    w_nxt_state = S_IDLE;
    if (w_pick_vld) begin
      w_nxt_state = w_pick_idx ? S_OWN1 : S_OWN0;
    end
  end

  // Ownership stage: state and grants move together, frozen while HREADY_IN=0.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else if (w_rearb) begin
      r_state <= w_nxt_state;
      r_gnt0  <= w_pick_vld & ~w_pick_idx;
      r_gnt1  <= w_pick_vld &  w_pick_idx;
    end
  end

  // Data-phase stage: records who owns the cycle after an accepted NONSEQ/SEQ.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dmst_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (bus.HREADY_IN) begin
      if (w_owned && w_own_trans[1]) begin
        r_dmst_p1 <= w_own_idx;
        r_vld_p1  <= 1'b1;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.HSELAPB = 1'b0;
    bus.HTRANS  = 2'b00;
    bus.HADDR   = '0;
    bus.HWRITE  = 1'b0;
    case (r_state)
      S_OWN0: begin
        bus.HSELAPB = 1'b1;
        bus.HTRANS  = bus.HTRANS0;
        bus.HADDR   = bus.HADDR0;
        bus.HWRITE  = bus.HWRITE0;
      end
      S_OWN1: begin
        bus.HSELAPB = 1'b1;
        bus.HTRANS  = bus.HTRANS1;
        bus.HADDR   = bus.HADDR1;
        bus.HWRITE  = bus.HWRITE1;
      end
      default: begin
        bus.HSELAPB = 1'b0;
      end
    endcase
  end

  assign bus.GNT0    = r_gnt0;
  assign bus.GNT1    = r_gnt1;
  assign bus.HMASTER = r_dmst_p1;
  assign bus.HDVALID = r_vld_p1;
  assign bus.HWDATA  = r_vld_p1 ? (r_dmst_p1 ? bus.HWDATA1 : bus.HWDATA0) : '0;

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// Directed bench for ahb_apb_arbiter: reset, handover, wait states, arbitration
// policy, direct switch, BUSY hold and asynchronous reset during a transfer.
module tb_ahb_apb_arbiter;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ahb_apb_arbiter_if bus ();

  ahb_apb_arbiter dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic go_idle();
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    bus.HREADY_IN = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1; bus.HREADY_IN = 1'b1;
    bus.HTRANS0 = 2'b10; bus.HTRANS1 = 2'b10;
    bus.HADDR0 = 32'h0000_0100; bus.HADDR1 = 32'h0000_0200;
    bus.HWRITE0 = 1'b1; bus.HWRITE1 = 1'b1;
    bus.HWDATA0 = 32'hDEAD_BEEF; bus.HWDATA1 = 32'hCAFE_F00D;
    tick();
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HMASTER, bus.HDVALID} !== 5'b00000) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=%b", {bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HMASTER, bus.HDVALID}, 5'b00000);
    end
    checks++;
    if ({bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA} !== 67'd0) begin
      failures++;
      $display("FAIL rst_addr got=%h exp=0", {bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA});
    end
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    HRESET = 1'b0;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB} !== 3'b000) begin
      failures++;
      $display("FAIL rst_noreq got=%b exp=%b", {bus.GNT0, bus.GNT1, bus.HSELAPB}, 3'b000);
    end
  endtask

  task automatic test_handover();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID} !== 4'b1010 || bus.HADDR !== 32'h0000_0100) begin
      failures++;
      $display("FAIL ho_first got=%b/%h exp=1010/00000100", {bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID}, bus.HADDR);
    end
    bus.REQ0 = 1'b0;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HDVALID, bus.HMASTER} !== 4'b0110 || bus.HADDR !== 32'h0000_0200) begin
      failures++;
      $display("FAIL ho_second got=%b/%h exp=0110/00000200", {bus.GNT0, bus.GNT1, bus.HDVALID, bus.HMASTER}, bus.HADDR);
    end
    bus.REQ1 = 1'b0;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER} !== 5'b00011 || bus.HWDATA !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL ho_release got=%b/%h exp=00011/cafef00d", {bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER}, bus.HWDATA);
    end
    tick();
    checks++;
    if (bus.HDVALID !== 1'b0 || bus.HWDATA !== 32'd0) begin
      failures++;
      $display("FAIL ho_dend got=%b/%h exp=0/00000000", bus.HDVALID, bus.HWDATA);
    end
  endtask

  task automatic test_wait_states();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b0;
    bus.HTRANS0 = 2'b10; bus.HADDR0 = 32'h4000_0010; bus.HWRITE0 = 1'b1;
    bus.HWDATA0 = 32'hA5A5_A5A5;
    tick();
    checks++;
    if ({bus.GNT0, bus.HWRITE} !== 2'b11 || bus.HADDR !== 32'h4000_0010) begin
      failures++;
      $display("FAIL ws_addr got=%b/%h exp=11/40000010", {bus.GNT0, bus.HWRITE}, bus.HADDR);
    end
    tick();
    bus.HREADY_IN = 1'b0;
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b1; bus.HTRANS0 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.GNT0, bus.GNT1, bus.HDVALID, bus.HMASTER} !== 4'b1010 || bus.HWDATA !== 32'hA5A5_A5A5) begin
        failures++;
        $display("FAIL ws_hold%0d got=%b/%h exp=1010/a5a5a5a5", i, {bus.GNT0, bus.GNT1, bus.HDVALID, bus.HMASTER}, bus.HWDATA);
      end
    end
    bus.HREADY_IN = 1'b1;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HDVALID} !== 3'b010 || bus.HWDATA !== 32'd0) begin
      failures++;
      $display("FAIL ws_release got=%b/%h exp=010/00000000", {bus.GNT0, bus.GNT1, bus.HDVALID}, bus.HWDATA);
    end
    go_idle();
  endtask

  task automatic test_policy();
    logic [1:0] exp;
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    bus.HTRANS0 = 2'b00; bus.HTRANS1 = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      exp = 2'b10;
`else
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      checks++;
      if ({bus.GNT0, bus.GNT1} !== exp) begin
        failures++;
        $display("FAIL policy%0d got=%b exp=%b", i, {bus.GNT0, bus.GNT1}, exp);
      end
    end
    go_idle();
  endtask

  task automatic test_direct_switch();
    bus.REQ1 = 1'b1; bus.HTRANS1 = 2'b10;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB} !== 3'b011) begin
      failures++;
      $display("FAIL sw_own1 got=%b exp=011", {bus.GNT0, bus.GNT1, bus.HSELAPB});
    end
    bus.REQ1 = 1'b0; bus.REQ0 = 1'b1; bus.HTRANS0 = 2'b10;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER} !== 5'b10111) begin
      failures++;
      $display("FAIL sw_own0 got=%b exp=10111", {bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER});
    end
  endtask

  task automatic test_reset_mid();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b1; bus.HTRANS1 = 2'b10;
    bus.HWDATA1 = 32'h1234_5678;
    tick();
    tick();
    checks++;
    if ({bus.GNT1, bus.HDVALID, bus.HMASTER} !== 3'b111 || bus.HWDATA !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rm_pre got=%b/%h exp=111/12345678", {bus.GNT1, bus.HDVALID, bus.HMASTER}, bus.HWDATA);
    end
    #2;
    HRESET = 1'b1;
    #1;
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER} !== 5'b00000 ||
        bus.HWDATA !== 32'd0 || bus.HADDR !== 32'd0) begin
      failures++;
      $display("FAIL rm_async got=%b/%h/%h exp=00000/0/0", {bus.GNT0, bus.GNT1, bus.HSELAPB, bus.HDVALID, bus.HMASTER}, bus.HWDATA, bus.HADDR);
    end
    tick();
    bus.REQ0 = 1'b1;
    HRESET = 1'b0;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1} !== 2'b10) begin
      failures++;
      $display("FAIL rm_first got=%b exp=10", {bus.GNT0, bus.GNT1});
    end
  endtask

  task automatic test_busy();
    logic [1:0] exp;
    bus.HTRANS0 = 2'b01;
    tick();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.HDVALID} !== 3'b100) begin
      failures++;
      $display("FAIL busy_hold got=%b exp=100", {bus.GNT0, bus.GNT1, bus.HDVALID});
    end
    bus.HTRANS0 = 2'b00;
    tick();
`ifdef ARB_FIXED_PRIO_EN
    exp = 2'b10;
`else
    exp = 2'b01;
`endif
    checks++;
    if ({bus.GNT0, bus.GNT1} !== exp) begin
      failures++;
      $display("FAIL busy_release got=%b exp=%b", {bus.GNT0, bus.GNT1}, exp);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_handover();
    test_wait_states();
    test_policy();
    test_direct_switch();
    test_reset_mid();
    test_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
